ps2_kbd_receiver: RTL and testbench

Host-side PS/2 keyboard receiver. It oversamples the device-driven `ps2_clk` and `ps2_data` lines with the system clock and assembles 11-bit frames. Valid scan-code bytes are pushed into a small FIFO and presented to a consumer through a ready/pop handshake. The block is instantiated as `ps2_keyboard` at the top level, beside the VGA and seven-segment blocks.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_fifo.sv | 73 +++++++
 rtl/ps2_kbd_receiver.sv | 89 ++++++++
 tb/tb_ps2_kbd_receiver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ps2_pkg : shared frame geometry, FIFO default and parity helper for PS/2 RX.
// Revision: 1.0
// ============================================================================
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FIFO_DEPTH = 8;

    localparam int PS2_START_IDX  = 0;
    localparam int PS2_PARITY_IDX = 9;
    localparam int PS2_STOP_IDX   = 10;

    // Data bits plus the parity bit must XOR to 1 for odd parity.
    function automatic logic ps2_odd_parity_ok(input logic [PS2_DATA_BITS:0] bits);
        return ^bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ps2_fifo : scan-code FIFO with one-slot-free full rule and sticky overflow.
// Revision: 1.0
// ============================================================================
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = PS2_FIFO_DEPTH,
    parameter int WIDTH = PS2_DATA_BITS
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_valid_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_n_i,
    output logic [WIDTH-1:0] data_o,
    output logic             ready_o,
    output logic             overflow_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    w_ptr_q, w_ptr_d;
    logic [PW-1:0]    r_ptr_q, r_ptr_d;
    logic             ovf_q, ovf_d;

    logic             pop;
    logic             full_after_pop;
    logic             push_ok;

    assign ready_o    = (w_ptr_q != r_ptr_q);
    assign data_o     = mem_q[r_ptr_q];
    assign overflow_o = ovf_q;

    always_comb begin
        pop            = ready_o & ~pop_n_i;
        r_ptr_d        = r_ptr_q + PW'(pop);
        // Fullness is judged against the post-pop read pointer.
        full_after_pop = ((w_ptr_q + PW'(1)) == r_ptr_d);
        push_ok        = push_valid_i & ~full_after_pop;
        w_ptr_d        = w_ptr_q + PW'(push_ok);

        ovf_d = ovf_q;
        if (push_valid_i && full_after_pop) begin
            ovf_d = 1'b1;
        end else if (pop) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            ovf_q   <= ovf_d;
            if (push_ok) begin
                mem_q[w_ptr_q] <= push_data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ps2_kbd_receiver : PS/2 keyboard frame receiver feeding a scan-code FIFO.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity rejection.
// Revision: 1.0
// ============================================================================
module ps2_kbd_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = PS2_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    input  logic                     nextdata_n,
    output logic [PS2_DATA_BITS-1:0] data,
    output logic                     ready,
    output logic                     overflow
);

    localparam int BUF_BITS = PS2_FRAME_BITS - 1;

    logic [2:0]          sync_q, sync_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [BUF_BITS-1:0] shift_q, shift_d;

    logic                ps2_fall;
    logic                frame_done;
    logic                parity_ok;
    logic                frame_ok;

    always_comb begin
        sync_d     = {sync_q[1:0], ps2_clk};
        ps2_fall   = sync_q[2] & ~sync_q[1];
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        if (ps2_fall) begin
            // Stop bit is checked live and never enters the buffer.
            if (bit_cnt_q == 4'(PS2_STOP_IDX)) begin
                bit_cnt_d  = 4'd0;
                frame_done = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shift_d   = {ps2_data, shift_q[BUF_BITS-1:1]};
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ps2_odd_parity_ok(shift_q[PS2_PARITY_IDX:1]);
`else
    logic unused_parity_bit;
    assign unused_parity_bit = shift_q[PS2_PARITY_IDX];
    assign parity_ok         = 1'b1;
`endif

    assign frame_ok = frame_done & ~shift_q[PS2_START_IDX] & ps2_data & parity_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q    <= 3'b111;
            bit_cnt_q <= 4'd0;
            shift_q   <= '0;
        end else begin
            sync_q    <= sync_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_DATA_BITS)
    ) u_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .push_valid_i (frame_ok),
        .push_data_i  (shift_q[PS2_DATA_BITS:1]),
        .pop_n_i      (nextdata_n),
        .data_o       (data),
        .ready_o      (ready),
        .overflow_o   (overflow)
    );

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_ps2_kbd_receiver : scoreboard bench for the PS/2 keyboard receiver.
// Revision: 1.0
// ============================================================================
module tb_ps2_kbd_receiver;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;

    int         tests = 0;
    int         fails = 0;
    int         ready_cycles = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    ps2_kbd_receiver #(.FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow)
    );

    // Monitor: every consumed byte is compared with the scoreboard head.
    always @(negedge clk) begin
        if (resetn && ready) ready_cycles++;
        if (resetn && ready && !nextdata_n) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no byte", data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (data !== mon_exp) begin
                    fails++;
                    $display("FAIL pop_data: got 0x%0h, expected 0x%0h", data, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit at 50 system clocks per PS/2 clock period.
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(12);
        ps2_clk = 1'b0;
        tick(25);
        ps2_clk = 1'b1;
        tick(13);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic flip);
        logic [10:0] f;
        f = mk_frame(b, flip);
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    endtask

    task automatic pop_once();
        nextdata_n = 1'b0;
        tick(1);
        nextdata_n = 1'b1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            tick(1);
            n++;
        end
        if (!ready) begin
            tests++;
            fails++;
            $display("FAIL %s: got ready=0 after 200 cycles, expected ready=1", name);
        end
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] f;
        int          lat;

        resetn     = 1'b0;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        tick(5);
        check("reset_ready", ready, 0);
        check("reset_overflow", overflow, 0);
        check("reset_data", data, 0);
        resetn = 1'b1;
        tick(5);

        // Single frame 0x1C, latency measured from the stop-bit fall.
        exp_q.push_back(8'h1C);
        f = mk_frame(8'h1C, 1'b0);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        check("ready_before_stop", ready, 0);
        ps2_data = 1'b1;
        tick(12);
        ps2_clk = 1'b0;
        lat = 0;
        while (!ready && lat < 10) begin
            tick(1);
            lat++;
        end
        check("push_latency_3_to_4", (lat >= 3 && lat <= 4), 1);
        check("single_data", data, 8'h1C);
        check("single_overflow", overflow, 0);
        tick(20);
        ps2_clk = 1'b1;
        tick(13);

        // Pop, then pop while empty.
        pop_once();
        check("pop_ready_low", ready, 0);
        pop_once();
        check("empty_pop_ready", ready, 0);
        check("empty_pop_overflow", overflow, 0);

        // Bad parity.
`ifdef PS2_PARITY_CHECK_EN
        send_frame(8'h1C, 1'b1);
        tick(5);
        check("bad_parity_dropped", ready, 0);
`else
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b1);
        wait_ready("bad_parity_ready");
        check("bad_parity_kept", data, 8'h1C);
        pop_once();
`endif

        // Overflow: eight frames, seven slots.
        for (int b = 1; b <= 8; b++) begin
            if (b <= 7) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b0);
            if (b == 7) check("no_overflow_at_7", overflow, 0);
        end
        tick(5);
        check("overflow_set", overflow, 1);
        check("overflow_ready", ready, 1);
        check("overflow_head", data, 8'h01);
        for (int k = 0; k < 7; k++) begin
            pop_once();
            if (k == 0) check("overflow_cleared", overflow, 0);
        end
        check("drained_ready", ready, 0);

        // Push and pop together with nextdata_n held low.
        ready_cycles = 0;
        nextdata_n   = 1'b0;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        send_frame(8'hAA, 1'b0);
        send_frame(8'h55, 1'b0);
        tick(5);
        nextdata_n = 1'b1;
        check("stream_ready_cycles", ready_cycles, 2);
        check("stream_overflow", overflow, 0);

        // Reset after five bits of a frame.
        f = mk_frame(8'h77, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(f[i]);
        resetn = 1'b0;
        #2;
        check("midreset_ready", ready, 0);
        tick(3);
        resetn = 1'b1;
        tick(3);
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b0);
        wait_ready("after_reset_ready");
        check("after_reset_data", data, 8'hF0);
        pop_once();
        check("after_reset_empty", ready, 0);

        tick(10);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
